gfilt_bank: RTL and testbench
=============================

# gfilt_bank

Multi-channel glitch filter: a parametrised bank of independent per-channel filters with input synchronisers, sample-enable prescaling and two selectable filter modes. Each channel emits a stable filtered level plus exactly-one-clock positive/negative edge pulses. It sits between raw front-panel, switch and peripheral-line inputs and the processor logic, replacing per-signal single-channel filter instances.

## Interface
- `CHANNELS`, 8: number of independent channels (1..32).
- `FILTER_COUNT`, 4: samples required to change state (2..255).
- `MODE`, 0: 0 = integrating (up/down saturating counter); 1 = consecutive (count restarts on any agreeing sample).
- `SYNC_STAGES`, 2: synchroniser flops per channel (1..3).
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ce` in 1: sample enable. Counters and filt update only on cycles with `ce`=1. Tie high for every-cycle sampling.
- `in` in CHANNELS: raw asynchronous inputs.
- `filt` out CHANNELS: filtered levels.
- `pedge` out CHANNELS: one-clock pulse on the filt 0→1 transition.
- `nedge` out CHANNELS: one-clock pulse on the filt 1→0 transition.

## Operation
- Per channel: `s` is the output of the SYNC_STAGES-deep synchroniser on `in`. The synchroniser runs every clock, independent of `ce`.
- Counter `cnt` has width CNT_W = $clog2(FILTER_COUNT+1). All compares use unsigned CNT_W arithmetic, with no overflow or underflow.
- MODE 0 (integrating), on `ce` cycles:
  - `s`=1 and cnt<FILTER_COUNT: cnt+1. If cnt==FILTER_COUNT-1, set filt=1.
  - `s`=1 and cnt==FILTER_COUNT: hold (saturate).
  - `s`=0 and cnt>0: cnt−1. If cnt==1, set filt=0.
  - `s`=0 and cnt==0: hold.
  - Result: hysteresis band. Alternating noise never toggles filt.
- MODE 1 (consecutive), on `ce` cycles:
  - `s`==filt: cnt=0.
  - `s`!=filt and cnt<FILTER_COUNT-1: cnt+1.
  - `s`!=filt and cnt==FILTER_COUNT-1: filt=s and cnt=0.
  - Result: filt changes only after FILTER_COUNT consecutive differing samples.
- Edge pulses:
  - pedge/nedge are registered. They are high for exactly the one clock in which filt has just changed, and deassert on the next clock regardless of `ce` or `in`.
  - pedge and nedge are never high together on one channel.
  - Re-assertion of a level that filt already holds generates no pulse.
- Channels are fully independent. Any combination of channels may pulse in the same cycle.
- `ce`=0: cnt and filt hold, and pedge/nedge are 0 on the following clock.

## Timing
- Reset (asynchronous assert, synchronous release via `clk`): sync flops=0, cnt=0, filt=0, pedge=0, nedge=0, evt=0, irq=0.
- No edge pulse is generated on reset release. Reset during a count discards that progress.
- Latency with `ce`=1, from a clean 0→1 step on `in` (from reset) to filt=1 and pedge=1: SYNC_STAGES+FILTER_COUNT clock edges. Both modes give the same latency.
- 1→0 latency from the saturated state:
  - MODE 0: SYNC_STAGES+FILTER_COUNT edges.
  - MODE 1: SYNC_STAGES+FILTER_COUNT edges.
- With `ce` strobed every P clocks, the count portion scales to FILTER_COUNT `ce` strobes. Synchroniser latency is unchanged.

## Configuration
- `GFILT_BANK_EVENT_EN` defined: adds the following ports.
  - `evt_clr` in CHANNELS.
  - `evt` out CHANNELS: sticky bits, set by pedge|nedge and cleared by evt_clr. If set and clear occur in the same cycle, set wins.
  - `irq` out 1: registered OR of evt, lagging evt by one clock.
- Not defined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package `gfilt_pkg` holds:
  - MODE encodings `GFILT_MODE_INTEG`=0 and `GFILT_MODE_CONSEC`=1.
  - Parameter range limits.
  - A CNT_W helper function.
- One sub-module, `gfilt_chan`: a single channel (synchroniser, counter, filt, edge pulses). `gfilt_bank` instantiates CHANNELS copies via generate and adds the optional event logic.
- Elaboration-time checks reject out-of-range parameters.

## Test plan
- Defaults, `ce`=1, channel 0 steps 0→1 at cycle 10: filt[0]=1 and pedge[0]=1 at edge 16. pedge[0]=0 at edge 17. Other channels stay 0.
- MODE 0: in[1] toggles every clock for 100 clocks: filt[1] never changes and no pulses occur. MODE 1, same stimulus: also no change.
- MODE 1, FILTER_COUNT=4: a high burst of 3 samples, one low sample, then steady high: filt rises only after 4 consecutive highs, with one pedge.
- `ce` every 4th clock, FILTER_COUNT=4: a step yields filt after 2 sync edges plus 4 strobes. The pulse is exactly one clock wide.
- Assert rst_n mid-count (cnt=3): all outputs go 0 asynchronously, with no pulse after release. The count restarts from 0.
- With GFILT_BANK_EVENT_EN: pedge[2] and evt_clr[2] in the same cycle leaves evt[2]=1, and irq=1 one clock later. A later clear alone leaves evt[2]=0 and irq=0.

Source files
------------

// File: rtl/gfilt_pkg.sv
// Shared definitions for the gfilt_bank glitch-filter bank: mode encodings,
// parameter limits and the counter-width helper.
package gfilt_pkg;

    localparam int GFILT_MODE_INTEG  = 0;
    localparam int GFILT_MODE_CONSEC = 1;

    localparam int GFILT_CHAN_MIN = 1;
    localparam int GFILT_CHAN_MAX = 32;
    localparam int GFILT_FC_MIN   = 2;
    localparam int GFILT_FC_MAX   = 255;
    localparam int GFILT_SYNC_MIN = 1;
    localparam int GFILT_SYNC_MAX = 3;

    // Counter must be able to hold FILTER_COUNT itself (integrating saturation).
    function automatic int gfilt_cnt_w(input int fc);
        return $clog2(fc + 1);
    endfunction

endpackage

// File: rtl/gfilt_chan.sv
// One glitch-filter channel: input synchroniser, integrating or consecutive
// sample counter, filtered level and registered one-clock edge pulses.
module gfilt_chan
    import gfilt_pkg::*;
#(
    parameter int FILTER_COUNT = 4,
    parameter int MODE         = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic in,
    output logic filt,
    output logic pedge,
    output logic nedge
);

    localparam int CNT_W = gfilt_cnt_w(FILTER_COUNT);
    localparam logic [CNT_W-1:0] FC_C  = CNT_W'(FILTER_COUNT);
    localparam logic [CNT_W-1:0] FC_M1 = CNT_W'(FILTER_COUNT - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO  = CNT_W'(0);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   filt_r;
    logic                   filt_nxt_s;
    logic                   pedge_r;
    logic                   nedge_r;
    logic                   s_s;

    assign s_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain runs every clock, independent of ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Next count / level for the selected filter mode; holds when ce is low.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        filt_nxt_s = filt_r;
        if (ce) begin
            if (MODE == GFILT_MODE_INTEG) begin
                if (s_s) begin
                    if (cnt_r < FC_C) begin
                        cnt_nxt_s  = cnt_r + ONE;
                        filt_nxt_s = (cnt_r == FC_M1) ? 1'b1 : filt_r;
                    end else begin
                        cnt_nxt_s  = cnt_r;
                        filt_nxt_s = filt_r;
                    end
                end else begin
                    if (cnt_r != ZERO) begin
                        cnt_nxt_s  = cnt_r - ONE;
                        filt_nxt_s = (cnt_r == ONE) ? 1'b0 : filt_r;
                    end else begin
                        cnt_nxt_s  = cnt_r;
                        filt_nxt_s = filt_r;
                    end
                end
            end else begin
                if (s_s == filt_r) begin
                    cnt_nxt_s  = ZERO;
                    filt_nxt_s = filt_r;
                end else if (cnt_r < FC_M1) begin
                    cnt_nxt_s  = cnt_r + ONE;
                    filt_nxt_s = filt_r;
                end else begin
                    cnt_nxt_s  = ZERO;
                    filt_nxt_s = s_s;
                end
            end
        end else begin
            cnt_nxt_s  = cnt_r;
            filt_nxt_s = filt_r;
        end
    end

    // Count/level state; pulses are registered alongside the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= ZERO;
            filt_r  <= 1'b0;
            pedge_r <= 1'b0;
            nedge_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            filt_r  <= filt_nxt_s;
            pedge_r <= filt_nxt_s & ~filt_r;
            nedge_r <= ~filt_nxt_s & filt_r;
        end
    end

    assign filt  = filt_r;
    assign pedge = pedge_r;
    assign nedge = nedge_r;

endmodule

// File: rtl/gfilt_bank.sv
// Bank of independent glitch-filter channels. Define GFILT_BANK_EVENT_EN to add
// sticky per-channel event bits (evt/evt_clr) and an aggregated irq.
module gfilt_bank
    import gfilt_pkg::*;
#(
    parameter int CHANNELS     = 8,
    parameter int FILTER_COUNT = 4,
    parameter int MODE         = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] filt,
    output logic [CHANNELS-1:0] pedge,
    output logic [CHANNELS-1:0] nedge
`ifdef GFILT_BANK_EVENT_EN
    ,
    input  logic [CHANNELS-1:0] evt_clr,
    output logic [CHANNELS-1:0] evt,
    output logic                irq
`endif
);

    if (CHANNELS < GFILT_CHAN_MIN || CHANNELS > GFILT_CHAN_MAX) begin : g_bad_chan
        $error("gfilt_bank: CHANNELS out of range");
    end
    if (FILTER_COUNT < GFILT_FC_MIN || FILTER_COUNT > GFILT_FC_MAX) begin : g_bad_fc
        $error("gfilt_bank: FILTER_COUNT out of range");
    end
    if (MODE != GFILT_MODE_INTEG && MODE != GFILT_MODE_CONSEC) begin : g_bad_mode
        $error("gfilt_bank: MODE out of range");
    end
    if (SYNC_STAGES < GFILT_SYNC_MIN || SYNC_STAGES > GFILT_SYNC_MAX) begin : g_bad_sync
        $error("gfilt_bank: SYNC_STAGES out of range");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        gfilt_chan #(
            .FILTER_COUNT (FILTER_COUNT),
            .MODE         (MODE),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .ce    (ce),
            .in    (in[g]),
            .filt  (filt[g]),
            .pedge (pedge[g]),
            .nedge (nedge[g])
        );
    end

`ifdef GFILT_BANK_EVENT_EN
    logic [CHANNELS-1:0] evt_r;
    logic                irq_r;

    // Sticky events: a new pulse beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_r <= '0;
            irq_r <= 1'b0;
        end else begin
            evt_r <= (evt_r & ~evt_clr) | pedge | nedge;
            irq_r <= |evt_r;
        end
    end

    assign evt = evt_r;
    assign irq = irq_r;
`endif

endmodule

// File: tb/tb_gfilt_bank.sv
// Directed self-checking bench for gfilt_bank: one integrating and one
// consecutive-mode instance share all inputs; expectations are hand-derived.
module tb_gfilt_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b1;
    logic [7:0] in = 8'h00;
    logic [7:0] f0, p0, n0, f1, p1, n1;
    int         total = 0;
    int         bad = 0;
`ifdef GFILT_BANK_EVENT_EN
    logic [7:0] evt_clr = 8'h00;
    logic [7:0] e0, e1;
    logic       i0, i1;
`endif

    always #5 clk = ~clk;

    gfilt_bank #(.CHANNELS(8), .FILTER_COUNT(4), .MODE(0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in(in),
        .filt(f0), .pedge(p0), .nedge(n0)
`ifdef GFILT_BANK_EVENT_EN
        , .evt_clr(evt_clr), .evt(e0), .irq(i0)
`endif
    );

    gfilt_bank #(.CHANNELS(8), .FILTER_COUNT(4), .MODE(1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in(in),
        .filt(f1), .pedge(p1), .nedge(n1)
`ifdef GFILT_BANK_EVENT_EN
        , .evt_clr(evt_clr), .evt(e1), .irq(i1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({f0, p0, n0, f1, p1, n1} !== 48'h0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", {f0, p0, n0, f1, p1, n1});
        end
`ifdef GFILT_BANK_EVENT_EN
        total++;
        if ({e0, i0, e1, i1} !== 18'h0) begin
            bad++;
            $display("FAIL reset_evt: got %h want 0", {e0, i0, e1, i1});
        end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({f0, p0, n0, f1, p1, n1} !== 48'h0) begin
                bad++;
                $display("FAIL reset_release k=%0d: got %h want 0", k, {f0, p0, n0, f1, p1, n1});
            end
        end
    endtask

    // Channel 0 rises then falls; both take 2 sync + 4 count edges.
    task automatic test_step();
        logic [7:0] ef, ep, en;
        in[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            ef = (k >= 6) ? 8'h01 : 8'h00;
            ep = (k == 6) ? 8'h01 : 8'h00;
            total++;
            if ({f0, p0, n0} !== {ef, ep, 8'h00}) begin
                bad++;
                $display("FAIL rise_m0 edge=%0d: got %h want %h", k, {f0, p0, n0}, {ef, ep, 8'h00});
            end
            total++;
            if ({f1, p1, n1} !== {ef, ep, 8'h00}) begin
                bad++;
                $display("FAIL rise_m1 edge=%0d: got %h want %h", k, {f1, p1, n1}, {ef, ep, 8'h00});
            end
        end
        in[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            ef = (k >= 6) ? 8'h00 : 8'h01;
            en = (k == 6) ? 8'h01 : 8'h00;
            total++;
            if ({f0, p0, n0} !== {ef, 8'h00, en}) begin
                bad++;
                $display("FAIL fall_m0 edge=%0d: got %h want %h", k, {f0, p0, n0}, {ef, 8'h00, en});
            end
            total++;
            if ({f1, p1, n1} !== {ef, 8'h00, en}) begin
                bad++;
                $display("FAIL fall_m1 edge=%0d: got %h want %h", k, {f1, p1, n1}, {ef, 8'h00, en});
            end
        end
    endtask

    task automatic test_toggle();
        for (int k = 0; k < 100; k++) begin
            in[1] = ~in[1];
            tick();
            total++;
            if ({f0, p0, n0, f1, p1, n1} !== 48'h0) begin
                bad++;
                $display("FAIL toggle k=%0d: got %h want 0", k, {f0, p0, n0, f1, p1, n1});
            end
        end
        in[1] = 1'b0;
        repeat (8) tick();
    endtask

    // Channel 3: three highs, one low, then steady high.
    task automatic test_burst();
        logic [7:0] ef0, ep0, ef1, ep1;
        for (int k = 0; k < 14; k++) begin
            in[3] = (k == 3) ? 1'b0 : 1'b1;
            tick();
            ef0 = (k + 1 >= 8)  ? 8'h08 : 8'h00;
            ep0 = (k + 1 == 8)  ? 8'h08 : 8'h00;
            ef1 = (k + 1 >= 10) ? 8'h08 : 8'h00;
            ep1 = (k + 1 == 10) ? 8'h08 : 8'h00;
            total++;
            if ({f0, p0, n0} !== {ef0, ep0, 8'h00}) begin
                bad++;
                $display("FAIL burst_m0 edge=%0d: got %h want %h", k + 1, {f0, p0, n0}, {ef0, ep0, 8'h00});
            end
            total++;
            if ({f1, p1, n1} !== {ef1, ep1, 8'h00}) begin
                bad++;
                $display("FAIL burst_m1 edge=%0d: got %h want %h", k + 1, {f1, p1, n1}, {ef1, ep1, 8'h00});
            end
        end
        in[3] = 1'b0;
        repeat (8) tick();
    endtask

    // Channel 4 with ce every 4th clock: counts on edges 4, 8, 12, 16.
    task automatic test_ce();
        logic [7:0] ef, ep;
        in[4] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ce = (k % 4 == 3) ? 1'b1 : 1'b0;
            tick();
            ef = (k + 1 >= 16) ? 8'h10 : 8'h00;
            ep = (k + 1 == 16) ? 8'h10 : 8'h00;
            total++;
            if ({f0, p0, n0} !== {ef, ep, 8'h00}) begin
                bad++;
                $display("FAIL ce_m0 edge=%0d: got %h want %h", k + 1, {f0, p0, n0}, {ef, ep, 8'h00});
            end
            total++;
            if ({f1, p1, n1} !== {ef, ep, 8'h00}) begin
                bad++;
                $display("FAIL ce_m1 edge=%0d: got %h want %h", k + 1, {f1, p1, n1}, {ef, ep, 8'h00});
            end
        end
        ce = 1'b1;
        in[4] = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset_midcount();
        logic [7:0] ef, ep;
        in[6] = 1'b1;
        repeat (7) tick();
        in[5] = 1'b1;
        repeat (5) tick();
        total++;
        if ({f0, f1} !== 16'h4040) begin
            bad++;
            $display("FAIL pre_reset: got %h want 4040", {f0, f1});
        end
        rst_n = 1'b0;
        #2;
        total++;
        if ({f0, p0, n0, f1, p1, n1} !== 48'h0) begin
            bad++;
            $display("FAIL async_reset: got %h want 0", {f0, p0, n0, f1, p1, n1});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            ef = (k >= 6) ? 8'h60 : 8'h00;
            ep = (k == 6) ? 8'h60 : 8'h00;
            total++;
            if ({f0, p0, n0} !== {ef, ep, 8'h00}) begin
                bad++;
                $display("FAIL restart_m0 edge=%0d: got %h want %h", k, {f0, p0, n0}, {ef, ep, 8'h00});
            end
            total++;
            if ({f1, p1, n1} !== {ef, ep, 8'h00}) begin
                bad++;
                $display("FAIL restart_m1 edge=%0d: got %h want %h", k, {f1, p1, n1}, {ef, ep, 8'h00});
            end
        end
        in[5] = 1'b0;
        in[6] = 1'b0;
        repeat (8) tick();
    endtask

`ifdef GFILT_BANK_EVENT_EN
    task automatic test_event();
        evt_clr = 8'hff;
        tick();
        evt_clr = 8'h00;
        tick();
        total++;
        if ({e0, i0, e1, i1} !== 18'h0) begin
            bad++;
            $display("FAIL evt_cleared: got %h want 0", {e0, i0, e1, i1});
        end
        in[2] = 1'b1;
        repeat (6) tick();
        total++;
        if ({p0, p1} !== 16'h0404) begin
            bad++;
            $display("FAIL evt_pedge: got %h want 0404", {p0, p1});
        end
        evt_clr = 8'h04;
        tick();
        evt_clr = 8'h00;
        total++;
        if ({e0, i0, e1, i1} !== {8'h04, 1'b0, 8'h04, 1'b0}) begin
            bad++;
            $display("FAIL evt_set_wins: got %h want %h", {e0, i0, e1, i1}, {8'h04, 1'b0, 8'h04, 1'b0});
        end
        tick();
        total++;
        if ({e0, i0, e1, i1} !== {8'h04, 1'b1, 8'h04, 1'b1}) begin
            bad++;
            $display("FAIL irq_lag: got %h want %h", {e0, i0, e1, i1}, {8'h04, 1'b1, 8'h04, 1'b1});
        end
        evt_clr = 8'h04;
        tick();
        evt_clr = 8'h00;
        total++;
        if ({e0, e1} !== 16'h0) begin
            bad++;
            $display("FAIL evt_clear: got %h want 0", {e0, e1});
        end
        tick();
        total++;
        if ({i0, i1} !== 2'b00) begin
            bad++;
            $display("FAIL irq_clear: got %b want 00", {i0, i1});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_step();
        test_toggle();
        test_burst();
        test_ce();
        test_reset_midcount();
`ifdef GFILT_BANK_EVENT_EN
        test_event();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
